cmp_lsu: RTL and testbench
==========================

Name: cmp_lsu

Overview:
Parametrised load/store unit between the EXMEM stage and data memory. It replaces the fixed single-cycle memEn/memWrEn/d_in path with a valid/ready request port and in-order tagged load responses, so multi-cycle and pipelined memories are supported. It buffers one request in an issue register and tracks up to DEPTH outstanding loads in a tag FIFO. It generates the pipeline stall and returns load data with its destination register to WB.

Parameters:
DATA_W, 64, data width of store/load data
ADDR_W, 32, memory address width
REG_AW, 5, register-index width (rD tag)
PPP_W, 3, width of ppp field carried with each load
DEPTH, 4, maximum outstanding loads; power of two, >=2

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  EXMEM memory operation present
req_wr  in  1  1=store, 0=load
req_addr  in  ADDR_W  address
req_wdata  in  DATA_W  store data
req_rd  in  REG_AW  load destination register
req_ppp  in  PPP_W  load ppp field, returned with data
stall  out  1  hold EXMEM and upstream this cycle
mem_en  out  1  memory request valid
mem_wr_en  out  1  memory request is a store
mem_addr  out  ADDR_W  request address
mem_wdata  out  DATA_W  request store data
mem_ready  in  1  memory accepts request when mem_en&&mem_ready
mem_rvalid  in  1  load data valid, in request order
mem_rdata  in  DATA_W  load data
wb_valid  out  1  load result valid for WB (one-cycle pulse)
wb_rd  out  REG_AW  load destination
wb_ppp  out  PPP_W  load ppp
wb_data  out  DATA_W  load data
err  out  1  sticky protocol error

Behaviour:
- Reset (reset=0, async): issue register empty, FIFO empty (rd/wr pointers 0, count 0), wb_valid=0, wb_rd/wb_ppp/wb_data=0, err=0, mem_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0. Reset mid-transaction drops all pending state. Responses arriving after reset with an empty FIFO set err.
- Issue register (ireg_v plus fields) is loaded when req_valid && !stall.
- mem_en = ireg_v && (ireg_wr || !fifo_full). mem_wr_en, mem_addr and mem_wdata come from ireg and are held stable while mem_en && !mem_ready.
- Request handshake fires when mem_en && mem_ready. On a load, {ireg_rd, ireg_ppp} is pushed into the FIFO. A store pushes nothing.
- stall = ireg_v && !(mem_en && mem_ready). ireg is refilled in the same cycle it is accepted, giving 1 request/cycle throughput.
- Latency: request accepted at edge N gives mem_en high in cycle N+1. mem_rvalid in cycle M gives wb_valid, wb_data=mem_rdata and the popped tag in cycle M+1.
- fifo_full uses the registered count only. A pop in the same cycle does not unblock a push; a push blocked this way waits one cycle.
- Simultaneous push and pop when not full: count unchanged, both pointers advance, pointers wrap mod DEPTH.
- mem_rvalid with FIFO empty: the response is ignored, wb_valid=0, err=1 until reset.
- wb_valid is 0 in every cycle not following an mem_rvalid that popped an entry.
- Stores never wait on outstanding loads. Memory ordering is the memory's responsibility (in-order acceptance).

Optional Feature:
CMP_LSU_PERF_EN
- Defined: adds outputs perf_stall_cnt (32) and perf_load_cnt (32), both reset to 0. They increment on each stall=1 cycle and each accepted load handshake respectively, and wrap at 2^32.
- Undefined: ports and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package cmp_pkg holds the default widths (DATA_W 64, ADDR_W 32, REG_AW 5, PPP_W 3) and a packed load-tag typedef {rd, ppp}.
- One sub-module: cmp_lsu_tag_fifo, a parametrised sync FIFO (DEPTH, tag width) with push/pop/full/empty/count and async active-low reset.

Test Plan:
1. Reset mid-flight: two loads outstanding, then reset pulse → all outputs 0, err=0. A following mem_rvalid sets err=1 with wb_valid=0.
2. Zero-wait memory: mem_ready=1, load rd=7 addr=0x40, rvalid with rdata=0xDEADBEEF 2 cycles later → stall=0 throughout; wb_valid pulses once with wb_rd=7, wb_data=0xDEADBEEF.
3. Backpressure: mem_ready=0 for 3 cycles with a store addr=0x80 wdata=0x1234 → stall=1 for 3 cycles, mem_addr/wdata held. Accepted on the 4th cycle, then stall=0.
4. FIFO full: DEPTH=4, issue 5 back-to-back loads with no rvalid → 4 handshakes. mem_en=0 and stall=1 on the 5th until one rvalid, then issued one cycle later.
5. In-order tags: loads rd=1,2,3 with rdata 0xA,0xB,0xC → wb outputs (1,0xA),(2,0xB),(3,0xC) in order. Stores interleaved produce no wb_valid.
6. With CMP_LSU_PERF_EN, scenario 4 → perf_load_cnt=5; perf_stall_cnt equals the count of stall=1 cycles.

Source files
------------

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared defaults for the CMP load/store path.
//   CMP_DATA_W / CMP_ADDR_W / CMP_REG_AW / CMP_PPP_W : default widths
//   cmp_tag_t : packed load tag {rd, ppp} carried from issue to writeback
package cmp_pkg;

    localparam int CMP_DATA_W = 64;
    localparam int CMP_ADDR_W = 32;
    localparam int CMP_REG_AW = 5;
    localparam int CMP_PPP_W  = 3;

    typedef struct packed {
        logic [CMP_REG_AW-1:0] rd;
        logic [CMP_PPP_W-1:0]  ppp;
    } cmp_tag_t;

endpackage

// File: rtl/cmp_lsu_tag_fifo.sv
// cmp_lsu_tag_fifo: synchronous FIFO holding tags of outstanding loads.
// Ports:
//   clk, reset (async, active-low)
//   push, push_data : write one entry (ignored when full)
//   pop,  pop_data  : pop_data shows the head; pop removes it (ignored when empty)
//   full, empty, count : occupancy, all derived from the registered count
module cmp_lsu_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full     = (count == CNT_W'(DEPTH));
        empty    = (count == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        pop_data = mem[rd_ptr];
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cmp_lsu.sv
// cmp_lsu: load/store unit between EXMEM and data memory.
// One-entry issue register feeds a valid/ready memory port; load tags
// wait in an in-order FIFO until mem_rvalid returns their data to WB.
// Optional macro CMP_LSU_PERF_EN adds perf_stall_cnt / perf_load_cnt.
// Ports:
//   clk, reset (async, active-low)
//   req_*   : memory operation from EXMEM; stall holds EXMEM
//   mem_*   : request (mem_en/mem_ready handshake) and in-order responses
//   wb_*    : one-cycle load result pulse with rd/ppp tag
//   err     : sticky, set by a response with no outstanding load
module cmp_lsu
    import cmp_pkg::*;
#(
    parameter int DATA_W = CMP_DATA_W,
    parameter int ADDR_W = CMP_ADDR_W,
    parameter int REG_AW = CMP_REG_AW,
    parameter int PPP_W  = CMP_PPP_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [REG_AW-1:0] req_rd,
    input  logic [PPP_W-1:0]  req_ppp,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [PPP_W-1:0]  wb_ppp,
    output logic [DATA_W-1:0] wb_data,
`ifdef CMP_LSU_PERF_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_load_cnt,
`endif
    output logic              err
);

    localparam int TAG_W = REG_AW + PPP_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              ireg_v;
    logic              ireg_wr;
    logic [ADDR_W-1:0] ireg_addr;
    logic [DATA_W-1:0] ireg_wdata;
    logic [REG_AW-1:0] ireg_rd;
    logic [PPP_W-1:0]  ireg_ppp;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [TAG_W-1:0]  head_tag;
    logic              handshake;
    logic              push;
    logic              pop;

    // Loads need a free tag slot before they may be offered; stores never wait.
    always_comb begin
        mem_en    = ireg_v && (ireg_wr || !fifo_full);
        handshake = mem_en && mem_ready;
        stall     = ireg_v && !handshake;
        push      = handshake && !ireg_wr;
        pop       = mem_rvalid && !fifo_empty;
    end

    assign mem_wr_en = ireg_wr;
    assign mem_addr  = ireg_addr;
    assign mem_wdata = ireg_wdata;

    // The issue register refills in the cycle it hands off, so a steady
    // stream keeps one request per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ireg_v     <= 1'b0;
            ireg_wr    <= 1'b0;
            ireg_addr  <= '0;
            ireg_wdata <= '0;
            ireg_rd    <= '0;
            ireg_ppp   <= '0;
        end else if (!stall) begin
            ireg_v <= req_valid;
            if (req_valid) begin
                ireg_wr    <= req_wr;
                ireg_addr  <= req_addr;
                ireg_wdata <= req_wdata;
                ireg_rd    <= req_rd;
                ireg_ppp   <= req_ppp;
            end
        end
    end

    cmp_lsu_tag_fifo #(
        .DEPTH (DEPTH),
        .W     (TAG_W)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({ireg_rd, ireg_ppp}),
        .pop       (pop),
        .pop_data  (head_tag),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_ppp   <= '0;
            wb_data  <= '0;
            err      <= 1'b0;
        end else begin
            wb_valid <= pop;
            if (pop) begin
                {wb_rd, wb_ppp} <= head_tag;
                wb_data         <= mem_rdata;
            end
            // A response with nothing outstanding is dropped and flagged.
            if (mem_rvalid && (fifo_count == '0)) err <= 1'b1;
        end
    end

`ifdef CMP_LSU_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_load_cnt  <= '0;
        end else begin
            if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (push)  perf_load_cnt  <= perf_load_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cmp_lsu.sv
// tb_cmp_lsu: directed self-checking bench for cmp_lsu (DEPTH=4).
// Inputs change 1 ns after the rising edge; outputs are checked mid-cycle.
module tb_cmp_lsu;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;
    logic [2:0]  req_ppp;
    logic        stall;
    logic        mem_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [2:0]  wb_ppp;
    logic [63:0] wb_data;
    logic        err;
`ifdef CMP_LSU_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_load_cnt;
    logic [31:0] stall_base;
    logic [31:0] load_base;
`endif

    int n_checks = 0;
    int n_errors = 0;

    cmp_lsu #(
        .DATA_W (64),
        .ADDR_W (32),
        .REG_AW (5),
        .PPP_W  (3),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .req_ppp    (req_ppp),
        .stall      (stall),
        .mem_en     (mem_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_ppp     (wb_ppp),
        .wb_data    (wb_data),
`ifdef CMP_LSU_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_load_cnt  (perf_load_cnt),
`endif
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ppp is derived from rd so each load carries a distinct, predictable ppp.
    task automatic drive(input logic v, input logic wr, input logic [31:0] a,
                         input logic [63:0] wd, input logic [4:0] rd,
                         input logic rdy, input logic rv, input logic [63:0] rdat);
        req_valid  = v;
        req_wr     = wr;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
        req_ppp    = rd[2:0] ^ 3'b101;
        mem_ready  = rdy;
        mem_rvalid = rv;
        mem_rdata  = rdat;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b0, 32'h0, 64'h0, 5'd0, rdy, 1'b0, 64'h0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle(1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_en",   64'(mem_en),   64'd0);
        check("rst_stall",    64'(stall),    64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_err",      64'(err),      64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        reset = 1'b1;
        next();

        // Zero-wait memory load.
        drive(1'b1, 1'b0, 32'h40, 64'h0, 5'd7, 1'b1, 1'b0, 64'h0);
        #4 check("zw_stall_issue", 64'(stall), 64'd0);
        next();
        idle(1'b1);
        #4;
        check("zw_mem_en",    64'(mem_en),    64'd1);
        check("zw_mem_addr",  64'(mem_addr),  64'h40);
        check("zw_mem_wr_en", 64'(mem_wr_en), 64'd0);
        check("zw_stall_hs",  64'(stall),     64'd0);
        next();
        drive(1'b0, 1'b0, 32'h0, 64'h0, 5'd0, 1'b1, 1'b1, 64'hDEADBEEF);
        #4;
        check("zw_wb_early",  64'(wb_valid), 64'd0);
        check("zw_mem_en_0",  64'(mem_en),   64'd0);
        next();
        idle(1'b1);
        #4;
        check("zw_wb_valid", 64'(wb_valid), 64'd1);
        check("zw_wb_rd",    64'(wb_rd),    64'd7);
        check("zw_wb_ppp",   64'(wb_ppp),   64'd2);
        check("zw_wb_data",  wb_data,       64'hDEADBEEF);
        next();
        #4 check("zw_wb_pulse", 64'(wb_valid), 64'd0);

        // Store under backpressure.
        drive(1'b1, 1'b1, 32'h80, 64'h1234, 5'd0, 1'b0, 1'b0, 64'h0);
        #4 check("bp_stall_issue", 64'(stall), 64'd0);
        next();
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            #4;
            check("bp_stall",     64'(stall),     64'd1);
            check("bp_mem_en",    64'(mem_en),    64'd1);
            check("bp_mem_wr_en", 64'(mem_wr_en), 64'd1);
            check("bp_mem_addr",  64'(mem_addr),  64'h80);
            check("bp_mem_wdata", mem_wdata,      64'h1234);
            next();
        end
        idle(1'b1);
        #4;
        check("bp_stall_accept", 64'(stall),  64'd0);
        check("bp_en_accept",    64'(mem_en), 64'd1);
        next();
        #4;
        check("bp_en_after",    64'(mem_en),   64'd0);
        check("bp_stall_after", 64'(stall),    64'd0);
        check("bp_no_wb",       64'(wb_valid), 64'd0);

`ifdef CMP_LSU_PERF_EN
        stall_base = perf_stall_cnt;
        load_base  = perf_load_cnt;
`endif
        // FIFO full: five back-to-back loads, no responses.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'h200 + 32'(8 * i), 64'h0, 5'(10 + i), 1'b1, 1'b0, 64'h0);
            #4;
            check("ff_stall_issue", 64'(stall),  64'd0);
            check("ff_mem_en",      64'(mem_en), (i == 0) ? 64'd0 : 64'd1);
            next();
        end
        for (int i = 0; i < 2; i++) begin
            idle(1'b1);
            #4;
            check("ff_full_en",    64'(mem_en), 64'd0);
            check("ff_full_stall", 64'(stall),  64'd1);
            next();
        end
        drive(1'b0, 1'b0, 32'h0, 64'h0, 5'd0, 1'b1, 1'b1, 64'h100);
        #4;
        check("ff_pop_cycle_en",    64'(mem_en), 64'd0);
        check("ff_pop_cycle_stall", 64'(stall),  64'd1);
        next();
        idle(1'b1);
        #4;
        check("ff_wb_valid",  64'(wb_valid), 64'd1);
        check("ff_wb_rd",     64'(wb_rd),    64'd10);
        check("ff_wb_ppp",    64'(wb_ppp),   64'd7);
        check("ff_wb_data",   wb_data,       64'h100);
        check("ff_reissue",   64'(mem_en),   64'd1);
        check("ff_reissue_s", 64'(stall),    64'd0);
        check("ff_reissue_a", 64'(mem_addr), 64'h220);
        next();
        #4 check("ff_drained_en", 64'(mem_en), 64'd0);
        next();
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, 1'b0, 32'h0, 64'h0, 5'd0, 1'b1, 1'b1, 64'h101 + 64'(j));
            next();
            check("ff_drain_valid", 64'(wb_valid), 64'd1);
            check("ff_drain_rd",    64'(wb_rd),    64'(11 + j));
            check("ff_drain_data",  wb_data,       64'h101 + 64'(j));
        end
        idle(1'b1);
        next();
        check("ff_drain_end", 64'(wb_valid), 64'd0);
        check("ff_err",       64'(err),      64'd0);
`ifdef CMP_LSU_PERF_EN
        check("perf_load_delta",  64'(perf_load_cnt - load_base),   64'd5);
        check("perf_stall_delta", 64'(perf_stall_cnt - stall_base), 64'd3);
`endif

        // In-order tags with interleaved stores (push and pop collide at c3).
        drive(1'b1, 1'b0, 32'h10, 64'h0, 5'd1, 1'b1, 1'b0, 64'h0);
        next();
        drive(1'b1, 1'b1, 32'h20, 64'h55, 5'd0, 1'b1, 1'b0, 64'h0);
        #4;
        check("io_en_c1",    64'(mem_en), 64'd1);
        check("io_stall_c1", 64'(stall),  64'd0);
        next();
        drive(1'b1, 1'b0, 32'h30, 64'h0, 5'd2, 1'b1, 1'b0, 64'h0);
        #4 check("io_store_wr", 64'(mem_wr_en), 64'd1);
        next();
        drive(1'b1, 1'b1, 32'h40, 64'h66, 5'd0, 1'b1, 1'b1, 64'hA);
        next();
        check("io_wb1_valid", 64'(wb_valid), 64'd1);
        check("io_wb1_rd",    64'(wb_rd),    64'd1);
        check("io_wb1_ppp",   64'(wb_ppp),   64'd4);
        check("io_wb1_data",  wb_data,       64'hA);
        drive(1'b1, 1'b0, 32'h50, 64'h0, 5'd3, 1'b1, 1'b1, 64'hB);
        next();
        check("io_wb2_rd",   64'(wb_rd), 64'd2);
        check("io_wb2_data", wb_data,    64'hB);
        idle(1'b1);
        #4;
        check("io_l3_en",   64'(mem_en),   64'd1);
        check("io_l3_addr", 64'(mem_addr), 64'h50);
        next();
        check("io_store_no_wb", 64'(wb_valid), 64'd0);
        drive(1'b0, 1'b0, 32'h0, 64'h0, 5'd0, 1'b1, 1'b1, 64'hC);
        next();
        check("io_wb3_valid", 64'(wb_valid), 64'd1);
        check("io_wb3_rd",    64'(wb_rd),    64'd3);
        check("io_wb3_ppp",   64'(wb_ppp),   64'd6);
        check("io_wb3_data",  wb_data,       64'hC);
        idle(1'b1);
        next();
        check("io_wb_end", 64'(wb_valid), 64'd0);
        check("io_err",    64'(err),      64'd0);

        // Reset with two loads outstanding and a third held in the issue register.
        drive(1'b1, 1'b0, 32'h300, 64'h0, 5'd20, 1'b1, 1'b0, 64'h0);
        next();
        drive(1'b1, 1'b0, 32'h308, 64'h0, 5'd21, 1'b1, 1'b0, 64'h0);
        next();
        drive(1'b1, 1'b0, 32'h310, 64'h0, 5'd22, 1'b1, 1'b0, 64'h0);
        next();
        idle(1'b0);
        #2;
        check("mf_pre_stall", 64'(stall), 64'd1);
        reset = 1'b0;
        #1;
        check("mf_mem_en",    64'(mem_en),    64'd0);
        check("mf_stall",     64'(stall),     64'd0);
        check("mf_mem_wr_en", 64'(mem_wr_en), 64'd0);
        check("mf_mem_addr",  64'(mem_addr),  64'd0);
        check("mf_mem_wdata", mem_wdata,      64'd0);
        check("mf_wb_valid",  64'(wb_valid),  64'd0);
        check("mf_wb_rd",     64'(wb_rd),     64'd0);
        check("mf_wb_ppp",    64'(wb_ppp),    64'd0);
        check("mf_wb_data",   wb_data,        64'd0);
        check("mf_err",       64'(err),       64'd0);
        next();
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 64'h0, 5'd0, 1'b1, 1'b1, 64'h77);
        next();
        check("mf_orphan_wb",  64'(wb_valid), 64'd0);
        check("mf_orphan_err", 64'(err),      64'd1);
        idle(1'b1);
        next();
        check("mf_err_sticky", 64'(err), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
